trace_pattern_matcher: RTL and testbench

- Upstream of the trigger/capture-enable stage: produces the single-cycle match pulse that stage consumes as its match input.
- Shifts the decoded trace byte stream into a pBYTES-wide sliding window.
- Compares the window against a programmable pattern/mask and emits a registered one-cycle match pulse.
- Arm-qualified fill and a programmable post-match holdoff prevent matches on stale data and bursts of back-to-back matches.

---
 rtl/trace_pattern_matcher_if.sv | 30 +++
 rtl/trace_pattern_matcher.sv | 130 +++++++++++++
 tb/tb_trace_pattern_matcher.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_pattern_matcher_if.sv
// Trace pattern matcher bus: trace byte stream, pattern/mask programming
// and match/state outputs, grouped for master (source) and slave (matcher).
interface trace_pattern_matcher_if #(
  parameter int pBYTES         = 8,
  parameter int pHOLDOFF_WIDTH = 16,
  parameter int pCOUNT_WIDTH   = 16
);
  logic                      I_arm;
  logic                      I_enable;
  logic [7:0]                I_data;
  logic                      I_data_valid;
  logic [8*pBYTES-1:0]       I_pattern;
  logic [8*pBYTES-1:0]       I_mask;
  logic [pHOLDOFF_WIDTH-1:0] I_holdoff;
  logic                      O_match;
  logic [1:0]                O_state;
  logic [pCOUNT_WIDTH-1:0]   O_match_count;

  modport master (
    output I_arm, I_enable, I_data, I_data_valid,
    output I_pattern, I_mask, I_holdoff,
    input  O_match, O_state, O_match_count
  );

  modport slave (
    input  I_arm, I_enable, I_data, I_data_valid,
    input  I_pattern, I_mask, I_holdoff,
    output O_match, O_state, O_match_count
  );
endinterface

// File: rtl/trace_pattern_matcher.sv
// Sliding-window trace byte matcher with arm-qualified fill and holdoff.
// Optional match counter enabled by defining TRACE_MATCH_COUNT_EN.
module trace_pattern_matcher #(
  parameter int pBYTES         = 8,
  parameter int pHOLDOFF_WIDTH = 16,
  parameter int pCOUNT_WIDTH   = 16
) (
  input  logic                     fe_clk,
  input  logic                     reset_n,
  trace_pattern_matcher_if.slave   bus
);

  localparam int W  = 8 * pBYTES;
  localparam int FW = $clog2(pBYTES + 1);
  localparam int HW = pHOLDOFF_WIDTH;

  localparam logic [FW-1:0] FONE = FW'(1);
  localparam logic [FW-1:0] FULL = FW'(pBYTES);
  localparam logic [HW-1:0] HONE = HW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    HUNT    = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  win_q;
  logic [FW-1:0] fill_q, fill_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          match_q, match_d;
  logic          valid_q;
  logic          arm_q;

  logic          arm_edge;
  logic          hit;
  logic [FW-1:0] fill_inc;

  assign arm_edge = bus.I_arm & ~arm_q;
  assign hit      = ((win_q ^ bus.I_pattern) & bus.I_mask) == '0;
  assign fill_inc = fill_q + FONE;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    hold_d  = hold_q;
    match_d = 1'b0;
    if (!bus.I_enable) begin
      state_d = IDLE;
      fill_d  = '0;
      hold_d  = '0;
    end else if (arm_edge) begin
      // the byte arriving with the arm edge is fill byte 1
      state_d = FILL;
      fill_d  = bus.I_data_valid ? FONE : '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        FILL: begin
          if (bus.I_data_valid) begin
            fill_d = fill_inc;
            if (fill_inc == FULL) state_d = HUNT;
          end
        end
        HUNT: begin
          if (valid_q && hit) begin
            match_d = 1'b1;
            if (bus.I_holdoff != '0) begin
              state_d = HOLDOFF;
              hold_d  = bus.I_holdoff;
            end
          end
        end
        HOLDOFF: begin
          if (hold_q <= HONE) begin
            state_d = HUNT;
            hold_d  = '0;
          end else begin
            hold_d  = hold_q - HONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      fill_q  <= '0;
      hold_q  <= '0;
      match_q <= 1'b0;
      valid_q <= 1'b0;
      arm_q   <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      match_q <= match_d;
      valid_q <= bus.I_data_valid;
      arm_q   <= bus.I_arm;
      if (bus.I_data_valid) win_q <= {win_q[W-9:0], bus.I_data};
    end
  end

  assign bus.O_match = match_q;
  assign bus.O_state = state_q;

`ifdef TRACE_MATCH_COUNT_EN
  logic [pCOUNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (arm_edge) begin
      cnt_q <= '0;
    end else if (match_d && !(&cnt_q)) begin
      cnt_q <= cnt_q + pCOUNT_WIDTH'(1);
    end
  end

  assign bus.O_match_count = cnt_q;
`else
  assign bus.O_match_count = '0;
`endif

endmodule

// File: tb/tb_trace_pattern_matcher.sv
// Self-checking bench for trace_pattern_matcher (pBYTES=4) against a
// byte-queue reference model plus directed test-plan scenarios.
module tb_trace_pattern_matcher;

  localparam int NB = 4;

  logic fe_clk  = 1'b0;
  logic reset_n = 1'b0;

  trace_pattern_matcher_if #(
    .pBYTES(NB), .pHOLDOFF_WIDTH(16), .pCOUNT_WIDTH(16)
  ) bus ();

  trace_pattern_matcher #(
    .pBYTES(NB), .pHOLDOFF_WIDTH(16), .pCOUNT_WIDTH(16)
  ) dut (
    .fe_clk (fe_clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 fe_clk = ~fe_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model: m_win[0] is the newest byte
  bit [7:0]    m_win[$];
  int          m_st, m_fill, m_hold;
  bit          m_vr, m_armr, m_match;
  int unsigned m_cnt;

  task automatic model_reset();
    m_win = '{8'h00, 8'h00, 8'h00, 8'h00};
    m_st = 0; m_fill = 0; m_hold = 0;
    m_vr = 0; m_armr = 0; m_match = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit edge_s, hit, nm;
    int ns, nf, nh;
    if (!reset_n) begin
      model_reset();
      return;
    end
    edge_s = bus.I_arm && !m_armr;
    hit = 1;
    for (int i = 0; i < NB; i++)
      if (((m_win[i] ^ bus.I_pattern[8*i +: 8]) & bus.I_mask[8*i +: 8]) != 0)
        hit = 0;
    ns = m_st; nf = m_fill; nh = m_hold; nm = 0;
    if (!bus.I_enable) begin
      ns = 0;
    end else if (edge_s) begin
      ns = 1;
      nf = bus.I_data_valid ? 1 : 0;
    end else if (m_st == 1) begin
      if (bus.I_data_valid) begin
        nf = m_fill + 1;
        if (nf == NB) ns = 2;
      end
    end else if (m_st == 2) begin
      if (m_vr && hit) begin
        nm = 1;
        if (bus.I_holdoff != 0) begin
          ns = 3;
          nh = int'(bus.I_holdoff);
        end
      end
    end else if (m_st == 3) begin
      if (m_hold <= 1) ns = 2;
      else nh = m_hold - 1;
    end
    if (edge_s) m_cnt = 0;
    else if (nm && m_cnt != 32'hFFFF) m_cnt++;
    if (bus.I_data_valid) begin
      m_win.push_front(bus.I_data);
      void'(m_win.pop_back());
    end
    m_st = ns; m_fill = nf; m_hold = nh;
    m_match = nm; m_vr = bus.I_data_valid; m_armr = bus.I_arm;
  endtask

  function automatic int unsigned exp_cnt();
`ifdef TRACE_MATCH_COUNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge fe_clk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic drive(input bit v, input bit [7:0] d);
    bus.I_data_valid = v;
    bus.I_data       = d;
  endtask

  task automatic test_reset();
    reset_n = 0;
    bus.I_arm = 0; bus.I_enable = 0;
    bus.I_pattern = '0; bus.I_mask = '0; bus.I_holdoff = '0;
    drive(0, 8'h00);
    model_reset();
    tick(); tick();
    reset_n = 1;
    tick();
    checks++;
    if (bus.O_match !== 1'b0 || bus.O_state !== 2'd0) begin
      errors++;
      $display("FAIL reset: match=%0b state=%0d expected 0/0",
               bus.O_match, bus.O_state);
    end
    checks++;
    if (bus.O_match_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", bus.O_match_count);
    end
  endtask

  task automatic test_basic_match();
    bit [7:0] s[6] = '{8'h11, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    int ef_e = -1, pulse_e = -1, pulses = 0;
    bus.I_pattern = 32'hDEADBEEF; bus.I_mask = 32'hFFFFFFFF;
    bus.I_holdoff = 0; bus.I_enable = 1; bus.I_arm = 0;
    drive(0, 0); tick();
    bus.I_arm = 1; tick();
    for (int i = 0; i < 9; i++) begin
      drive(i < 6, i < 6 ? s[i] : 8'h00);
      tick();
      if (i == 4) ef_e = cyc;
      if (bus.O_match === 1'b1) begin pulses++; pulse_e = cyc; end
      checks++;
      if (bus.O_match !== m_match || bus.O_state !== 2'(m_st)) begin
        errors++;
        $display("FAIL basic_model: match=%0b/%0b state=%0d/%0d",
                 bus.O_match, m_match, bus.O_state, m_st);
      end
    end
    // EF valid in cycle t; pulse visible one edge after EF is sampled
    checks++;
    if (pulses != 1 || pulse_e != ef_e + 1) begin
      errors++;
      $display("FAIL basic_latency: pulses=%0d at %0d expected 1 at %0d",
               pulses, pulse_e, ef_e + 1);
    end
  endtask

  task automatic test_prearm_fill();
    bit [7:0] s[5] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    int pulses = 0;
    bus.I_enable = 0; bus.I_arm = 0;
    drive(0, 0); tick();
    bus.I_enable = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) bus.I_arm = 1;
      if (i < 4) drive(1, s[i]);
      else if (i == 6) drive(1, s[4]);
      else drive(0, 0);
      tick();
      if (bus.O_match === 1'b1) pulses++;
      checks++;
      if (bus.O_match !== m_match || bus.O_state !== 2'(m_st)) begin
        errors++;
        $display("FAIL prearm_model: match=%0b/%0b state=%0d/%0d",
                 bus.O_match, m_match, bus.O_state, m_st);
      end
    end
    checks++;
    if (pulses != 0 || bus.O_state !== 2'd2) begin
      errors++;
      $display("FAIL prearm: pulses=%0d state=%0d expected 0 and 2",
               pulses, bus.O_state);
    end
  endtask

  task automatic test_masked();
    bit [7:0] a[4] = '{8'hAA, 8'h55, 8'hBB, 8'h77};
    bit [7:0] b[4] = '{8'hAA, 8'h55, 8'hBC, 8'h77};
    int pa = 0, pb = 0;
    bit last_a = 0;
    bus.I_pattern = 32'hAA00BB00; bus.I_mask = 32'hFF00FF00;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) drive(1, a[i]);
      else if (i >= 5 && i < 9) drive(1, b[i-5]);
      else drive(0, 0);
      tick();
      if (bus.O_match === 1'b1) begin
        if (i < 5) pa++; else pb++;
      end
      if (i == 4) last_a = bus.O_match;
      checks++;
      if (bus.O_match !== m_match || bus.O_state !== 2'(m_st)) begin
        errors++;
        $display("FAIL masked_model: match=%0b/%0b state=%0d/%0d",
                 bus.O_match, m_match, bus.O_state, m_st);
      end
    end
    checks++;
    if (pa != 1 || last_a !== 1'b1) begin
      errors++;
      $display("FAIL masked_hit: pulses=%0d last=%0b expected 1/1",
               pa, last_a);
    end
    checks++;
    if (pb != 0) begin
      errors++;
      $display("FAIL masked_miss: pulses=%0d expected 0", pb);
    end
  endtask

  task automatic test_holdoff();
    int pe[$];
    int hcnt = 0;
    bus.I_holdoff = 3; bus.I_mask = '0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 8'(i * 3 + 1));
      tick();
      if (bus.O_match === 1'b1) pe.push_back(cyc);
      if (pe.size() == 1 && bus.O_state === 2'd3) hcnt++;
      checks++;
      if (bus.O_match !== m_match || bus.O_state !== 2'(m_st)) begin
        errors++;
        $display("FAIL holdoff_model: match=%0b/%0b state=%0d/%0d",
                 bus.O_match, m_match, bus.O_state, m_st);
      end
    end
    checks++;
    if (pe.size() < 3) begin
      errors++;
      $display("FAIL holdoff_pulses: got %0d expected >=3", pe.size());
    end else begin
      for (int k = 1; k < pe.size(); k++) begin
        checks++;
        if (pe[k] - pe[k-1] != 4) begin
          errors++;
          $display("FAIL holdoff_gap: got %0d expected 4", pe[k] - pe[k-1]);
        end
      end
      checks++;
      if (hcnt != 3) begin
        errors++;
        $display("FAIL holdoff_state: HOLDOFF cycles=%0d expected 3", hcnt);
      end
    end
    bus.I_holdoff = 0; bus.I_mask = 32'hFFFFFFFF;
    drive(0, 0);
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_arm_abort();
    bit [7:0] s[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    bus.I_pattern = 32'hDEADBEEF; bus.I_arm = 0;
    drive(0, 0); tick();
    for (int i = 0; i < 4; i++) begin drive(1, s[i]); tick(); end
    bus.I_arm = 1; drive(0, 0); tick();
    checks++;
    if (bus.O_match !== 1'b0 || bus.O_state !== 2'd1 ||
        bus.O_match_count !== 16'd0) begin
      errors++;
      $display("FAIL abort: match=%0b state=%0d cnt=%0d expected 0/1/0",
               bus.O_match, bus.O_state, bus.O_match_count);
    end
    for (int i = 0; i < 4; i++) begin drive(1, s[i]); tick(); end
    drive(0, 0); tick();
    checks++;
    if (bus.O_match !== 1'b1 || bus.O_match_count !== 16'(exp_cnt())) begin
      errors++;
      $display("FAIL refill_match: match=%0b cnt=%0d expected 1/%0d",
               bus.O_match, bus.O_match_count, exp_cnt());
    end
`ifdef TRACE_MATCH_COUNT_EN
    checks++;
    if (bus.O_match_count !== 16'd1) begin
      errors++;
      $display("FAIL refill_count: got %0d expected 1", bus.O_match_count);
    end
`endif
  endtask

  task automatic test_enable_reset();
    int pulses = 0;
    bit seen = 0;
    bus.I_holdoff = 3; bus.I_mask = '0;
    for (int i = 0; i < 10 && !seen; i++) begin
      drive(1, 8'h5A); tick();
      if (bus.O_state === 2'd3) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reach_holdoff: state=%0d expected 3", bus.O_state);
    end
    bus.I_enable = 0; tick();
    checks++;
    if (bus.O_state !== 2'd0) begin
      errors++;
      $display("FAIL enable_drop: state=%0d expected 0", bus.O_state);
    end
    bus.I_enable = 1;
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'(i)); tick();
      if (bus.O_match === 1'b1 || bus.O_state !== 2'd0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL held_arm: %0d bad cycles expected 0", pulses);
    end
    bus.I_arm = 0; drive(0, 0); tick();
    bus.I_arm = 1; drive(1, 8'h01); tick();
    drive(1, 8'h02); tick();
    #2 reset_n = 0;
    #1;
    model_reset();
    checks++;
    if (bus.O_state !== 2'd0 || bus.O_match !== 1'b0 ||
        bus.O_match_count !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: state=%0d match=%0b cnt=%0d expected 0",
               bus.O_state, bus.O_match, bus.O_match_count);
    end
    bus.I_arm = 0;
    tick(); tick();
    reset_n = 1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'(i + 9)); tick();
      if (bus.O_match === 1'b1 || bus.O_state !== 2'd0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL post_reset: %0d bad cycles expected 0", pulses);
    end
  endtask

  task automatic test_random();
    bit [31:0] masks[4] = '{32'hFFFFFFFF, 32'h0, 32'hFF00FF00, 32'h0000FFFF};
    int bad = 0;
    bus.I_pattern = 32'h01020300;
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom_range(0, 3)));
      if ($urandom_range(0, 19) == 0) bus.I_arm = ~bus.I_arm;
      bus.I_enable = $urandom_range(0, 49) != 0;
      if ($urandom_range(0, 29) == 0)
        bus.I_mask = masks[$urandom_range(0, 3)];
      if ($urandom_range(0, 29) == 0)
        bus.I_holdoff = 16'($urandom_range(0, 3));
      tick();
      checks++;
      if (bus.O_match !== m_match || bus.O_state !== 2'(m_st) ||
          bus.O_match_count !== 16'(exp_cnt())) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL random@%0d: match=%0b/%0b state=%0d/%0d cnt=%0d/%0d",
                   cyc, bus.O_match, m_match, bus.O_state, m_st,
                   bus.O_match_count, exp_cnt());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_match();
    test_prearm_fill();
    test_masked();
    test_holdoff();
    test_arm_abort();
    test_enable_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
